// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - shares one sram-like bus port between i_cache and d_cache (ARB_RR_EN selects round-robin)
module cache_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // The counter must be able to reach the limit, otherwise inst could starve forever.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > (1 << CNT_W) - 1) begin : g_bad_params
    $error("cache_bus_arbiter: CNT_W too narrow for STARVE_LIMIT");
  end

  state_t state;
  logic   owner;
  logic   bus_req_q;
  logic   any_req;
  logic   grant_data;

`ifdef ARB_RR_EN
  logic rr_last;
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;
`endif

  assign any_req = inst_req | data_req;

  // Pick the winner for the next transaction from the live requests seen in IDLE.
  always_comb begin
    grant_data = data_req;
`ifdef ARB_RR_EN
    if (inst_req && data_req) begin
      grant_data = (rr_last == OWN_INST);
    end
`else
    starve_next = '0;
    if (inst_req && data_req && starve_cnt >= LIMIT) begin
      grant_data = 1'b0;
    end
    // Count only data grants that made a waiting inst request wait; saturate at the limit.
    if (inst_req && grant_data) begin
      starve_next = (starve_cnt >= LIMIT) ? starve_cnt : starve_cnt + CNT_W'(1);
    end
`endif
  end

  // Transaction FSM: latch the owner at grant and hold it until the bridge returns data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= OWN_INST;
      bus_req_q <= 1'b0;
`ifdef ARB_RR_EN
      rr_last   <= OWN_INST;
`else
      starve_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifndef ARB_RR_EN
          starve_cnt <= starve_next;
`endif
          if (any_req) begin
            owner     <= grant_data ? OWN_DATA : OWN_INST;
            state     <= S_ADDR;
            bus_req_q <= 1'b1;
`ifdef ARB_RR_EN
            rr_last   <= grant_data ? OWN_DATA : OWN_INST;
`endif
          end
        end
        S_ADDR: begin
          if (bus_addr_ok) begin
            bus_req_q <= 1'b0;
            state     <= bus_data_ok ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (bus_data_ok) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Request fields are not registered: the owner holds them stable until its addr_ok.
  assign bus_req   = bus_req_q;
  assign bus_wr    = (owner == OWN_DATA) ? data_wr    : inst_wr;
  assign bus_size  = (owner == OWN_DATA) ? data_size  : inst_size;
  assign bus_addr  = (owner == OWN_DATA) ? data_addr  : inst_addr;
  assign bus_wdata = (owner == OWN_DATA) ? data_wdata : inst_wdata;

  // Handshakes reach only the owner; data_ok in IDLE is a stray and is dropped.
  assign inst_addr_ok = bus_addr_ok & (state == S_ADDR) & (owner == OWN_INST);
  assign data_addr_ok = bus_addr_ok & (state == S_ADDR) & (owner == OWN_DATA);
  assign inst_data_ok = bus_data_ok & (state != S_IDLE) & (owner == OWN_INST);
  assign data_data_ok = bus_data_ok & (state != S_IDLE) & (owner == OWN_DATA);

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule
